// File: rtl/beat_packer_pkg.sv
// Shared widths and the packed word record passed from the packer accumulator
// to its output holding register.
package beat_packer_pkg;

    localparam int IN_W  = 4;
    localparam int BEATS = 5;
    localparam int OUT_W = IN_W * BEATS;
    localparam int CNT_W = $clog2(BEATS + 1);

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [CNT_W-1:0] beats;
        logic             last;
    } word_t;

endpackage

// File: rtl/beat_packer_obuf.sv
// Single-entry output register: loads a completed word and holds it stable
// until the downstream consumer takes it.
module beat_packer_obuf
    import beat_packer_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  load,
    input  word_t word_in,
    input  logic  i_ready,
    output logic  o_valid,
    output word_t word_out,
    output logic  free
);

    logic  valid_r;
    word_t word_r;

    // A load wins over a simultaneous drain, so back-to-back words leave no bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_r <= 1'b0;
            word_r  <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            word_r  <= word_in;
        end else if (i_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign o_valid  = valid_r;
    assign word_out = word_r;
    assign free     = !valid_r || i_ready;

endmodule

// File: rtl/beat_packer.sv
// Packs narrow beats into wide words, first beat in the low slice; a last
// marker flushes a zero-padded partial word with its beat count.
module beat_packer
    import beat_packer_pkg::*;
#(
    parameter int IN_WIDTH = IN_W,
    parameter int RATIO    = BEATS
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [IN_WIDTH-1:0]           i_data,
    input  logic                          i_last,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [IN_WIDTH*RATIO-1:0]     o_data,
    output logic [$clog2(RATIO+1)-1:0]    o_beats,
    output logic                          o_last
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    logic [OUT_WIDTH-1:0] acc_data_r, acc_data_n, merged_s;
    logic [CNT_W-1:0]     count_r, count_n;
    logic                 acc_last_r, acc_last_n;
    logic                 acc_full_r, acc_full_n;
    logic [1:0]           state_s;
    logic                 in_fire_s, complete_s, free_s, load_s;
    word_t                load_word_s, out_word_s;

    // Accumulator contents with the incoming beat dropped into its slice.
    always_comb begin
        merged_s = acc_data_r;
        merged_s[count_r*IN_WIDTH +: IN_WIDTH] = i_data;
    end

    // Control state is implied by the accumulator fill level and hold flag.
    always_comb begin
        if (acc_full_r) begin
            state_s = ST_HELD;
        end else if (count_r != {CNT_W{1'b0}}) begin
            state_s = ST_FILLING;
        end else begin
            state_s = ST_EMPTY;
        end
    end

    assign in_fire_s  = i_valid && !acc_full_r;
    assign complete_s = in_fire_s && ((count_r == LAST_IDX) || i_last);

    // Decide where a completed word goes and how the accumulator moves.
    always_comb begin
        acc_data_n  = acc_data_r;
        count_n     = count_r;
        acc_last_n  = acc_last_r;
        acc_full_n  = acc_full_r;
        load_s      = 1'b0;
        load_word_s = '0;
        case (state_s)
            ST_HELD: begin
                if (free_s) begin
                    load_s            = 1'b1;
                    load_word_s.data  = acc_data_r;
                    load_word_s.beats = count_r + CNT_ONE;
                    load_word_s.last  = acc_last_r;
                    acc_data_n        = {OUT_WIDTH{1'b0}};
                    count_n           = {CNT_W{1'b0}};
                    acc_last_n        = 1'b0;
                    acc_full_n        = 1'b0;
                end else begin
                    acc_full_n = 1'b1;
                end
            end
            ST_EMPTY, ST_FILLING: begin
                if (complete_s && free_s) begin
                    load_s            = 1'b1;
                    load_word_s.data  = merged_s;
                    load_word_s.beats = count_r + CNT_ONE;
                    load_word_s.last  = i_last;
                    acc_data_n        = {OUT_WIDTH{1'b0}};
                    count_n           = {CNT_W{1'b0}};
                    acc_last_n        = 1'b0;
                end else if (complete_s) begin
                    // Count is kept so the held word still knows its beat total.
                    acc_data_n = merged_s;
                    acc_last_n = i_last;
                    acc_full_n = 1'b1;
                end else if (in_fire_s) begin
                    acc_data_n = merged_s;
                    count_n    = count_r + CNT_ONE;
                end else begin
                    count_n = count_r;
                end
            end
            default: begin
                acc_data_n = {OUT_WIDTH{1'b0}};
                count_n    = {CNT_W{1'b0}};
                acc_last_n = 1'b0;
                acc_full_n = 1'b0;
            end
        endcase
    end

    // Accumulator registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_data_r <= {OUT_WIDTH{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            acc_last_r <= 1'b0;
            acc_full_r <= 1'b0;
        end else begin
            acc_data_r <= acc_data_n;
            count_r    <= count_n;
            acc_last_r <= acc_last_n;
            acc_full_r <= acc_full_n;
        end
    end

    beat_packer_obuf u_obuf (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .load     (load_s),
        .word_in  (load_word_s),
        .i_ready  (i_ready),
        .o_valid  (o_valid),
        .word_out (out_word_s),
        .free     (free_s)
    );

    assign o_ready = !acc_full_r;
    assign o_data  = out_word_s.data;
    assign o_beats = out_word_s.beats;
    assign o_last  = out_word_s.last;

endmodule

// File: tb/tb_beat_packer.sv
// Directed scenarios plus randomized traffic checked against a beat-list
// reference model of the packer.
module tb_beat_packer;

    localparam int IW = 4;
    localparam int R  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic [IW-1:0] i_data = '0;
    logic          i_last = 1'b0;
    logic          i_ready = 1'b0;
    logic          o_ready, o_valid, o_last;
    logic [IW*R-1:0] o_data;
    logic [2:0]    o_beats;

    int checks = 0;
    int failures = 0;

    int cur[$];
    logic [31:0] exp_data[$];
    int exp_beats[$];
    int exp_last[$];

    beat_packer dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_beats(o_beats), .o_last(o_last)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [IW-1:0] d, input logic l);
        logic r;
        bit done = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        for (int k = 0; k < 40 && !done; k++) begin
            r = o_ready;
            tick();
            if (r) done = 1;
        end
        if (!done) check_val("accept_timeout", 32'd0, 32'd1);
    endtask

    // Reference model and output-protocol monitor, sampled mid-cycle.
    initial begin
        logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [19:0] pd = '0;
        logic [2:0]  pb = '0;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (rst) begin
                cur.delete(); exp_data.delete(); exp_beats.delete(); exp_last.delete();
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check_val("hold_valid", {31'd0, o_valid}, 32'd1);
                    check_val("hold_data", {12'd0, o_data}, {12'd0, pd});
                    check_val("hold_meta", {28'd0, o_beats, o_last}, {28'd0, pb, pl});
                end
                if (o_valid && i_ready) begin
                    if (exp_data.size() == 0) begin
                        check_val("unexpected_word", {12'd0, o_data}, 32'hFFFFFFFF);
                    end else begin
                        check_val("sb_data", {12'd0, o_data}, exp_data.pop_front());
                        check_val("sb_beats", {29'd0, o_beats}, exp_beats.pop_front());
                        check_val("sb_last", {31'd0, o_last}, exp_last.pop_front());
                    end
                end
                if (i_valid && o_ready) begin
                    cur.push_back(int'(i_data));
                    if (i_last || cur.size() == R) begin
                        w = 0;
                        for (int k = 0; k < cur.size(); k++) w = w + (cur[k] << (IW * k));
                        exp_data.push_back(w);
                        exp_beats.push_back(cur.size());
                        exp_last.push_back(int'(i_last));
                        cur.delete();
                    end
                end
                pv = o_valid; pr = i_ready; pd = o_data; pb = o_beats; pl = o_last;
            end
        end
    end

    initial begin
        bit acc;
        logic r;
        #12;
        check_val("rst_valid", {31'd0, o_valid}, 32'd0);
        check_val("rst_data", {12'd0, o_data}, 32'd0);
        check_val("rst_beats", {29'd0, o_beats}, 32'd0);
        check_val("rst_last", {31'd0, o_last}, 32'd0);
        check_val("rst_ready", {31'd0, o_ready}, 32'd1);
        rst = 1'b0;
        i_ready = 1'b1;
        tick();

        // Full word
        for (int k = 1; k <= 5; k++) begin
            check_val("full_ready", {31'd0, o_ready}, 32'd1);
            send(4'(k), 1'b0);
        end
        check_val("full_valid", {31'd0, o_valid}, 32'd1);
        check_val("full_data", {12'd0, o_data}, 32'h54321);
        check_val("full_beats", {29'd0, o_beats}, 32'd5);
        check_val("full_last", {31'd0, o_last}, 32'd0);

        // Short packet, then a lone beat landing in slice 0
        send(4'hA, 1'b0);
        send(4'hB, 1'b1);
        check_val("short_data", {12'd0, o_data}, 32'h000BA);
        check_val("short_beats", {29'd0, o_beats}, 32'd2);
        check_val("short_last", {31'd0, o_last}, 32'd1);
        send(4'hC, 1'b1);
        check_val("slice0_data", {12'd0, o_data}, 32'h0000C);
        check_val("slice0_beats", {29'd0, o_beats}, 32'd1);
        i_valid = 1'b0;
        tick(); tick();

        // Backpressure
        i_ready = 1'b0;
        for (int k = 1; k <= 10; k++) send(4'(k), 1'b0);
        check_val("bp_ready_low", {31'd0, o_ready}, 32'd0);
        check_val("bp_first", {12'd0, o_data}, 32'h54321);
        i_valid = 1'b1; i_data = 4'hB; i_last = 1'b1;
        tick();
        check_val("bp_ready_stays", {31'd0, o_ready}, 32'd0);
        check_val("bp_first_held", {12'd0, o_data}, 32'h54321);
        i_ready = 1'b1;
        tick();
        check_val("bp_second", {12'd0, o_data}, 32'hA9876);
        check_val("bp_second_valid", {31'd0, o_valid}, 32'd1);
        check_val("bp_ready_back", {31'd0, o_ready}, 32'd1);
        tick();
        check_val("bp_beat_b", {12'd0, o_data}, 32'h0000B);
        check_val("bp_beat_b_beats", {29'd0, o_beats}, 32'd1);
        i_valid = 1'b0; i_last = 1'b0;
        tick();

        // Back-to-back full words
        for (int k = 0; k < 10; k++) begin
            check_val("b2b_ready", {31'd0, o_ready}, 32'd1);
            send(4'(k + 1), 1'b0);
            if (k == 4) check_val("b2b_w1", {12'd0, o_data}, 32'h54321);
            if (k == 9) check_val("b2b_w2", {12'd0, o_data}, 32'hA9876);
            if (k == 4 || k == 9) check_val("b2b_valid", {31'd0, o_valid}, 32'd1);
        end
        i_valid = 1'b0;
        tick();

        // Reset mid-word
        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0);
        i_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_val("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check_val("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) send(4'h7, 1'b0);
        check_val("post_rst_data", {12'd0, o_data}, 32'h77777);
        check_val("post_rst_beats", {29'd0, o_beats}, 32'd5);

        // Last on the full beat
        for (int k = 1; k <= 5; k++) send(4'(k), k == 5);
        check_val("lastfull_data", {12'd0, o_data}, 32'h54321);
        check_val("lastfull_beats", {29'd0, o_beats}, 32'd5);
        check_val("lastfull_last", {31'd0, o_last}, 32'd1);
        i_valid = 1'b0; i_last = 1'b0;
        tick();

        // Randomized traffic; a beat not yet accepted is held unchanged
        acc = 1;
        for (int n = 0; n < 4000; n++) begin
            if (!i_valid || acc) begin
                i_valid = ($urandom % 4) != 0;
                i_data  = 4'($urandom);
                i_last  = ($urandom % 6) == 0;
            end
            i_ready = ($urandom % 3) != 0;
            r = o_ready;
            tick();
            acc = i_valid && r;
        end

        // Flush any partial word and drain the output
        i_ready = 1'b1;
        send(4'h1, 1'b1);
        i_valid = 1'b0; i_last = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check_val("drain_empty", 32'(exp_data.size()), 32'd0);
        check_val("drain_idle", {31'd0, o_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/beat_packer.md
# beat_packer

Packs a stream of narrow input beats into wide output words by concatenation, first beat in the least-significant slice. It sits directly upstream of the wide-bus consumers, turning a serial nibble stream into the 20-bit words they take in one transfer. Both sides use valid/ready handshakes. A last marker flushes a partial word, zero-padded, with a beat count.

## Interface
Parameters:
- IN_WIDTH, 4: input beat width in bits (≥1).
- RATIO, 5: beats per output word (≥2). The output width OUT_WIDTH = IN_WIDTH*RATIO.

Ports:
- i_clk  input  1  clock; all state changes on its rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_valid  input  1  input beat valid.
- o_ready  output  1  packer can accept a beat.
- i_data  input  IN_WIDTH  input beat.
- i_last  input  1  beat is the final beat of a packet; qualified by i_valid.
- o_valid  output  1  output word valid.
- i_ready  input  1  downstream accepts the word.
- o_data  output  OUT_WIDTH  packed word.
- o_beats  output  $clog2(RATIO+1)  number of valid beats in o_data, from 1 to RATIO.
- o_last  output  1  word closes a packet.

## Operation
- An input transfer occurs when i_valid && o_ready. An output transfer occurs when o_valid && i_ready.
- The accumulator holds acc_data[OUT_WIDTH], count (0..RATIO-1), acc_last and acc_full.
- On an input transfer, i_data is written to slice [count*IN_WIDTH +: IN_WIDTH].
- The word completes when count == RATIO-1 or i_last == 1. The completed word is {slices beyond count = 0, written slices}, with beats = count+1 and last = i_last.
- Completed word, output free (!o_valid || i_ready in the same cycle): the word loads into the output register. The accumulator then clears: data 0, count 0.
- Completed word, output busy: the word stays in the accumulator and acc_full is set.
- While acc_full is set: o_ready = 0. When the output frees, the word transfers to the output register, and the accumulator clears along with acc_full.
- Incomplete word: count increments. Unwritten slices stay 0, which is the padding.
- o_ready = !acc_full. It is a registered term, so there is no combinational path from i_ready or i_valid.
- States: EMPTY (count 0, !acc_full), FILLING (count > 0), HELD (acc_full).
  - EMPTY→FILLING on a beat that does not complete the word.
  - FILLING/EMPTY→HELD on completion with the output busy.
  - HELD→EMPTY on transfer to the output register.
- Beats presented while o_ready = 0 are ignored. Upstream must hold them.
- Once asserted, o_valid holds with o_data, o_beats and o_last stable until an output transfer occurs.

## Timing
- Reset values: o_valid = 0, o_data = 0, o_beats = 0, o_last = 0, o_ready = 1. count, acc_full and acc_data are 0.
- Reset mid-word discards the partial beats and any pending or held word. The first beat after reset lands in slice 0.
- Latency: o_valid rises the cycle after the completing beat is accepted, if the output is free.
- Throughput: one beat per cycle sustained when i_ready = 1. Full words are emitted every RATIO cycles with no bubble.
- Simultaneous output transfer and completing input beat: the new word replaces the old one in the same edge, and o_valid stays high.
- With i_last on the first beat, o_beats = 1. With i_last on the RATIO-th beat, the output is a normal full word with o_last = 1.
- i_data and i_last are don't-care when i_valid = 0.

## Structure
- Shared package beat_packer_pkg holds:
  - the count width constant, derived with $clog2(RATIO+1);
  - a packed struct word_t {data, beats, last} used by both the accumulator and the output register.
- One sub-module is natural: beat_packer_obuf.
  - It is a single-entry output holding register with ports load/word_t in, o_valid/i_ready, and free = !o_valid || i_ready.
  - The packer top contains the accumulator, completion logic and the HELD/EMPTY control.

## Test plan
With IN_WIDTH = 4 and RATIO = 5:
- Full word: i_ready = 1, beats 1,2,3,4,5 on consecutive cycles → one cycle after beat 5, o_data = 20'h54321, o_beats = 5, o_last = 0. o_ready stays 1 throughout.
- Short packet: beats A, B with i_last on B → o_data = 20'h000BA, o_beats = 2, o_last = 1. A following beat C lands in slice 0.
- Backpressure:
  - i_ready = 0 while beats 1..5 then 6,7,8,9,A are sent: the first word sits in the output, and the second fills the accumulator. o_ready drops the cycle after A and stays 0, and beat B is held by upstream.
  - Raise i_ready: 20'h54321, then 20'hA9876 on the next cycle. o_ready returns to 1 after the second load.
- Back-to-back: two full words streamed with i_ready = 1 → o_valid is high in consecutive RATIO-cycle windows with no gap, and o_data updates on the edge where the completing beat is accepted.
- Reset mid-word: 3 beats, then i_rst pulsed → o_valid = 0, o_ready = 1. The next beats 7,7,7,7,7 yield 20'h77777 only.
- Last on the full beat: beats 1..5 with i_last on 5 → 20'h54321, o_beats = 5, o_last = 1.
